// File: rtl/pad_bus_responder.sv
// pad_bus_responder
//   Core-side responder for a 4-phase parallel command bus driven by an
//   external tester through the input pads. Decodes read/write commands
//   against a small scratch register file and answers on the output pads.
//
// Ports
//   io_clock    core clock
//   io_reset_n  asynchronous active-low reset
//   ui_in[15:0] raw pad inputs (async): [15] strb, [14] we, [13:8] addr,
//               [7:0] wdata
//   uo_out[15:0] output pads: [15] ack, [14] err, [13:8] addr echo,
//               [7:0] rdata
//   reg_q       scratch register contents, reg n at [8n+7:8n]
module pad_bus_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic                  io_clock,
  input  logic                  io_reset_n,
  input  logic [15:0]           ui_in,
  output logic [15:0]           uo_out,
  output logic [NUM_REGS*8-1:0] reg_q
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    EXEC,
    ACK
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]            r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_fill;

  logic       w_s_strb;
  logic       w_s_we;
  logic [5:0] w_s_addr;
  logic [7:0] w_s_wdata;

  logic       r_we;
  logic [5:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_txn;
  logic [7:0] r_regs [NUM_REGS];
  logic       r_ack;
  logic [14:0] r_resp;

  logic       w_hit;
  logic [7:0] w_reg_rd;
  logic [7:0] w_rdata;
  logic       w_err;
  logic       w_wr;

  assign w_s_strb  = r_sync[SYNC_STAGES-1][15];
  assign w_s_we    = r_sync[SYNC_STAGES-1][14];
  assign w_s_addr  = r_sync[SYNC_STAGES-1][13:8];
  assign w_s_wdata = r_sync[SYNC_STAGES-1][7:0];

  // r_fill marks when the sync chain holds post-reset samples only. The
  // chain resets to 0, so without it a strb held high across reset release
  // would look like a low-then-high edge and start a transaction.
  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_fill <= '0;
    end else begin
      r_sync[0] <= ui_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_state <= WAIT_LOW;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_LOW: if (r_fill[SYNC_STAGES-1] && !w_s_strb) w_next = IDLE;
      IDLE:     if (w_s_strb) w_next = EXEC;
      EXEC:     w_next = ACK;
      ACK:      if (!w_s_strb) w_next = IDLE;
      default:  w_next = WAIT_LOW;
    endcase
  end

  // Address decode of the captured command.
  always_comb begin
    w_hit    = 1'b0;
    w_reg_rd = '0;
    w_rdata  = '0;
    w_err    = 1'b0;
    w_wr     = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (r_addr == 6'(i)) begin
        w_hit    = 1'b1;
        w_reg_rd = r_regs[i];
      end
    end
    if (w_hit) begin
      w_wr    = r_we;
      w_rdata = r_we ? r_wdata : w_reg_rd;
    end else if (r_addr == 6'h3E) begin
      w_rdata = r_txn;
      w_err   = r_we;
    end else if (r_addr == 6'h3F) begin
      w_rdata = ID_VALUE;
      w_err   = r_we;
    end else begin
      w_err   = 1'b1;
    end
  end

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_txn   <= '0;
      r_ack   <= 1'b0;
      r_resp  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (r_state == IDLE && w_s_strb) begin
        r_we    <= w_s_we;
        r_addr  <= w_s_addr;
        r_wdata <= w_s_wdata;
      end
      if (r_state == EXEC) begin
        r_txn  <= r_txn + 8'd1;
        r_resp <= {w_err, r_addr, w_rdata};
        r_ack  <= 1'b1;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (w_wr && r_addr == 6'(i)) begin
            r_regs[i] <= r_wdata;
          end
        end
      end
      if (r_state == ACK && !w_s_strb) begin
        r_ack <= 1'b0;
      end
    end
  end

  assign uo_out = {r_ack, r_resp};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[8*g +: 8] = r_regs[g];
  end

endmodule

// File: tb/tb_pad_bus_responder.sv
module tb_pad_bus_responder;

  localparam int unsigned NREGS = 8;

  logic              clk;
  logic              rst_n;
  logic [15:0]       ui;
  logic [15:0]       uo;
  logic [NREGS*8-1:0] rq;

  int n_checks = 0;
  int n_fail   = 0;

  pad_bus_responder #(
    .SYNC_STAGES(2),
    .NUM_REGS(NREGS),
    .ID_VALUE(8'hA5)
  ) dut (
    .io_clock  (clk),
    .io_reset_n(rst_n),
    .ui_in     (ui),
    .uo_out    (uo),
    .reg_q     (rq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[14];
  logic [NREGS*8-1:0] exp_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Full 4-phase handshake; latencies are -1 when the bound expires.
  task automatic do_txn(input logic we, input logic [5:0] addr, input logic [7:0] wdata,
                        output logic [15:0] resp, output int rise_lat, output int fall_lat);
    @(negedge clk);
    ui = {1'b0, we, addr, wdata};
    @(negedge clk);
    ui[15] = 1'b1;
    rise_lat = -1;
    resp = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (uo[15]) begin
        rise_lat = c;
        resp = uo;
        break;
      end
    end
    ui[15] = 1'b0;
    fall_lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!uo[15]) begin
        fall_lat = c;
        break;
      end
    end
  endtask

  logic [15:0] resp;
  int rl, fl, ack_seen;

  initial begin
    tbl[0]  = '{1'b0, 6'h3F, 8'h00, 1'b0, 8'hA5};
    tbl[1]  = '{1'b1, 6'h3F, 8'h00, 1'b1, 8'hA5};
    tbl[2]  = '{1'b0, 6'h3F, 8'h00, 1'b0, 8'hA5};
    tbl[3]  = '{1'b1, 6'h20, 8'hFF, 1'b1, 8'h00};
    tbl[4]  = '{1'b0, 6'h20, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 6'h00, 8'h11, 1'b0, 8'h11};
    tbl[6]  = '{1'b1, 6'h07, 8'hEE, 1'b0, 8'hEE};
    tbl[7]  = '{1'b0, 6'h03, 8'h00, 1'b0, 8'h5C};
    tbl[8]  = '{1'b0, 6'h00, 8'h00, 1'b0, 8'h11};
    tbl[9]  = '{1'b0, 6'h3E, 8'h00, 1'b0, 8'h0A};
    tbl[10] = '{1'b1, 6'h3E, 8'h55, 1'b1, 8'h0B};
    tbl[11] = '{1'b0, 6'h3E, 8'h00, 1'b0, 8'h0C};
    tbl[12] = '{1'b0, 6'h08, 8'h00, 1'b1, 8'h00};
    tbl[13] = '{1'b1, 6'h01, 8'hA1, 1'b0, 8'hA1};

    // Reset with strb held high across release.
    rst_n = 1'b0;
    ui = 16'h8000;
    repeat (3) @(negedge clk);
    check("reset_uo", 64'(uo), 64'h0);
    check("reset_regq", 64'(rq), 64'h0);
    rst_n = 1'b1;
    ack_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uo[15]) ack_seen++;
    end
    check("strb_held_no_ack", 64'(ack_seen), 64'h0);
    check("strb_held_no_write", 64'(rq), 64'h0);
    ui = 16'h0000;
    repeat (4) @(negedge clk);

    // First real transaction: write reg 3.
    exp_q = '0;
    do_txn(1'b1, 6'h03, 8'h5C, resp, rl, fl);
    exp_q[31:24] = 8'h5C;
    check_rng("w3_rise_lat", rl, 3, 5);
    check("w3_resp", 64'(resp[14:0]), 64'h035C);
    check("w3_regq", 64'(rq), 64'(exp_q));
    check_rng("w3_fall_lat", fl, 3, 3);
    check("w3_held_in_idle", 64'(uo), 64'h035C);

    for (int i = 0; i < 14; i++) begin
      do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, resp, rl, fl);
      if (tbl[i].we && tbl[i].addr < 6'(NREGS))
        exp_q[8*tbl[i].addr +: 8] = tbl[i].wdata;
      check($sformatf("tbl%0d_ack_lat", i), 64'(rl > 0), 64'h1);
      check($sformatf("tbl%0d_resp", i), 64'(resp[14:0]),
            64'({tbl[i].err, tbl[i].addr, tbl[i].rdata}));
      check($sformatf("tbl%0d_regq", i), 64'(rq), 64'(exp_q));
    end

    // Counter is 15; 241 more transactions bring it to 256 -> wraps to 0.
    for (int i = 0; i < 241; i++) begin
      do_txn(1'b0, 6'h00, 8'h00, resp, rl, fl);
    end
    do_txn(1'b0, 6'h3E, 8'h00, resp, rl, fl);
    check("cnt_wrap_00", 64'(resp[14:0]), 64'h3E00);
    do_txn(1'b0, 6'h3E, 8'h00, resp, rl, fl);
    check("cnt_wrap_01", 64'(resp[14:0]), 64'h3E01);

    // Command fields changed while in ACK must be ignored.
    @(negedge clk);
    ui = {1'b0, 1'b1, 6'h02, 8'h33};
    @(negedge clk);
    ui[15] = 1'b1;
    repeat (6) @(negedge clk);
    ui[13:0] = {6'h05, 8'h77};
    repeat (6) @(negedge clk);
    exp_q[23:16] = 8'h33;
    check("ack_change_uo", 64'(uo), 64'h8233);
    check("ack_change_regq", 64'(rq), 64'(exp_q));
    ui[15] = 1'b0;
    repeat (5) @(negedge clk);
    check("ack_change_drop", 64'(uo[15]), 64'h0);

    // Reset while in ACK after a write to reg 1.
    @(negedge clk);
    ui = {1'b0, 1'b1, 6'h01, 8'h42};
    @(negedge clk);
    ui[15] = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_ack", 64'(uo[15]), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rst_ack_uo", 64'(uo), 64'h0);
    check("rst_ack_regq", 64'(rq), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uo[15]) ack_seen++;
    end
    check("post_rst_no_ack", 64'(ack_seen), 64'h0);
    ui[15] = 1'b0;
    repeat (4) @(negedge clk);
    do_txn(1'b0, 6'h01, 8'h00, resp, rl, fl);
    check_rng("post_rst_rise_lat", rl, 3, 5);
    check("post_rst_read1", 64'(resp[14:0]), 64'h0100);
    do_txn(1'b0, 6'h3E, 8'h00, resp, rl, fl);
    check("post_rst_cnt", 64'(resp[14:0]), 64'h3E01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
